mac_spike_scheduler: RTL and testbench

- Sequences and shares one mac10-style accumulate unit among N_REQ spike sources (router/NoC ports).
- Generates the MAC initialisation pulse (set) after reset and the per-timestep clear window.
- Round-robin arbitrates incoming source addresses onto the MAC's single source_address input.
- Reports per-timestep spike counts and a timestep index to the neuron controller.

---
 rtl/mac_spike_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_mac_spike_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_spike_scheduler.sv
// Shares one accumulate unit among N_REQ spike sources: post-reset set pulse, round-robin
// address forwarding, an end-of-timestep clear window and per-timestep spike bookkeeping.
module mac_spike_scheduler #(
  parameter int N_REQ           = 4,
  parameter int ADDR_W          = 12,
  parameter int TIMESTEP_CYCLES = 16,
  parameter int CLEAR_CYCLES    = 1,
  parameter int SET_CYCLES      = 2,
  parameter int CNT_W           = 16,
  parameter int TS_W            = 16
) (
  input  logic                      CLK_Mac,
  input  logic                      rst_n,
  input  logic                      run_en,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]         mac_src_addr,
  output logic                      mac_src_valid,
  output logic                      mac_set,
  output logic                      mac_clear,
  output logic                      timestep_done,
  output logic [TS_W-1:0]           timestep_index,
  output logic [CNT_W-1:0]          spike_count,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TSC_W = $clog2(TIMESTEP_CYCLES);
  localparam int SET_W = $clog2(SET_CYCLES + 1);
  localparam logic [TSC_W-1:0] RUN_LAST   = TSC_W'(TIMESTEP_CYCLES - CLEAR_CYCLES - 1);
  localparam logic [TSC_W-1:0] GRANT_LAST = TSC_W'(TIMESTEP_CYCLES - CLEAR_CYCLES - 2);
  localparam logic [TSC_W-1:0] TS_LAST    = TSC_W'(TIMESTEP_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SET_CYCLES);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  if (TIMESTEP_CYCLES < CLEAR_CYCLES + 2 || CLEAR_CYCLES < 1 || SET_CYCLES < 1) begin : g_bad_params
    $error("mac_spike_scheduler: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SET_W-1:0]   r_set_cnt;
  logic [SET_W-1:0]   w_set_cnt_nxt;
  logic [TSC_W-1:0]   r_ts_cnt;
  logic [TSC_W-1:0]   w_ts_cnt_nxt;
  logic               w_boundary;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mac_set;
  logic               r_mac_clear;
  logic               r_busy;
  logic               r_done;
  logic [TS_W-1:0]    r_index;
  logic [CNT_W-1:0]   r_spike_count;
  logic [ADDR_W-1:0]  r_src_addr;
  logic               r_src_valid;
  logic               w_grant_ok;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_idx;
  logic               w_xfer;
  logic [ADDR_W-1:0]  w_addr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
    assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
  end

  // Handshake: requester i keeps req_valid[i] and its address stable until it sees
  // req_ready[i]; a transfer happens in any cycle where both are high, and the address
  // appears on mac_src_addr with mac_src_valid one cycle later.
  always_comb begin
    w_grant_ok = rst_n && (r_state == S_RUN) && (r_ts_cnt <= GRANT_LAST);
    w_found    = 1'b0;
    w_win      = '0;
    w_idx      = '0;
    // Descending scan so the lowest offset from the pointer wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (int'(r_ptr) + k >= N_REQ) w_idx = PTR_W'(int'(r_ptr) + k - N_REQ);
      else                          w_idx = PTR_W'(int'(r_ptr) + k);
      if (w_grant_ok && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    req_ready = '0;
    if (w_found) req_ready[w_win] = 1'b1;
  end

  assign w_xfer = |(req_valid & req_ready);

  always_comb begin
    w_state_nxt   = r_state;
    w_ts_cnt_nxt  = r_ts_cnt;
    w_set_cnt_nxt = r_set_cnt;
    w_boundary    = 1'b0;
    case (r_state)
      S_INIT: begin
        if (r_set_cnt == SET_LAST) w_state_nxt = run_en ? S_RUN : S_IDLE;
        else                       w_set_cnt_nxt = r_set_cnt + 1'b1;
      end
      S_IDLE: begin
        if (run_en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_ts_cnt_nxt = r_ts_cnt + 1'b1;
        if (r_ts_cnt == RUN_LAST) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        // run_en only matters here, so a timestep always runs to completion.
        if (r_ts_cnt == TS_LAST) begin
          w_boundary   = 1'b1;
          w_ts_cnt_nxt = '0;
          w_state_nxt  = run_en ? S_RUN : S_IDLE;
        end else begin
          w_ts_cnt_nxt = r_ts_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge CLK_Mac) begin
    if (!rst_n) begin
      r_state       <= S_INIT;
      r_set_cnt     <= '0;
      r_ts_cnt      <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_mac_set     <= 1'b0;
      r_mac_clear   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_index       <= '0;
      r_spike_count <= '0;
      r_src_addr    <= '0;
      r_src_valid   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_set_cnt   <= w_set_cnt_nxt;
      r_ts_cnt    <= w_ts_cnt_nxt;
      r_mac_set   <= (r_state == S_INIT) && (r_set_cnt != SET_LAST);
      r_mac_clear <= (w_state_nxt == S_CLEAR);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_boundary;
      r_src_valid <= w_xfer;
      // The MAC reacts to address changes, so the address only moves on a real spike.
      if (w_xfer) begin
        r_src_addr <= w_addr[w_win];
        r_ptr      <= (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
      end
      if (w_boundary) begin
        r_spike_count <= r_cnt;
        r_cnt         <= '0;
        r_index       <= r_index + 1'b1;
      end else if (w_xfer && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign mac_src_addr   = r_src_addr;
  assign mac_src_valid  = r_src_valid;
  assign mac_set        = r_mac_set;
  assign mac_clear      = r_mac_clear;
  assign timestep_done  = r_done;
  assign timestep_index = r_index;
  assign spike_count    = r_spike_count;
  assign busy           = r_busy;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mac_spike_scheduler.sv
// Directed bench for mac_spike_scheduler: default instance plus a CNT_W=3 instance for saturation.
module tb_mac_spike_scheduler;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        run_en;
  logic [3:0]  rv;
  logic [11:0] ra [4];
  logic [47:0] req_addr;
  assign req_addr = {ra[3], ra[2], ra[1], ra[0]};

  logic [3:0]  req_ready;
  logic [11:0] mac_src_addr;
  logic        mac_src_valid, mac_set, mac_clear, timestep_done, busy;
  logic [15:0] timestep_index, spike_count;
  logic [1:0]  dbg_state;

  logic [3:0]  s_req_ready;
  logic [11:0] s_src_addr;
  logic        s_src_valid, s_set, s_clear, s_done, s_busy;
  logic [15:0] s_index;
  logic [2:0]  s_spike_count;
  logic [1:0]  s_state;

  mac_spike_scheduler u_dut (
    .CLK_Mac(clk), .rst_n(rst_n), .run_en(run_en),
    .req_valid(rv), .req_addr(req_addr), .req_ready(req_ready),
    .mac_src_addr(mac_src_addr), .mac_src_valid(mac_src_valid),
    .mac_set(mac_set), .mac_clear(mac_clear), .timestep_done(timestep_done),
    .timestep_index(timestep_index), .spike_count(spike_count),
    .busy(busy), .dbg_state(dbg_state)
  );

  mac_spike_scheduler #(.CNT_W(3)) u_sat (
    .CLK_Mac(clk), .rst_n(rst_n), .run_en(run_en),
    .req_valid(4'hF), .req_addr(req_addr), .req_ready(s_req_ready),
    .mac_src_addr(s_src_addr), .mac_src_valid(s_src_valid),
    .mac_set(s_set), .mac_clear(s_clear), .timestep_done(s_done),
    .timestep_index(s_index), .spike_count(s_spike_count),
    .busy(s_busy), .dbg_state(s_state)
  );

  // scoreboard
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;
  int total = 0;
  int bad = 0;
  int g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("src_vs_clear", 32'(mac_src_valid & mac_clear), 32'd0);
    if (mac_src_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL src_unexpected: got addr %0d, required no spike (t=%0t)", mac_src_addr, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("src_addr", 32'(mac_src_addr), 32'(mon_exp));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle at timestep position k: checks grant and clear, records the expected spike.
  task automatic ts_cycle(input int k, input logic [3:0] exp_rdy);
    #1;
    check("grant", 32'(req_ready), 32'(exp_rdy));
    check("clear", 32'(mac_clear), 32'(k == 15));
    if (k > 0) check("done_low", 32'(timestep_done), 32'd0);
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) exp_q.push_back(ra[i]);
    step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_set"},   32'(mac_set), 32'd0);
    check({tag, "_clear"}, 32'(mac_clear), 32'd0);
    check({tag, "_valid"}, 32'(mac_src_valid), 32'd0);
    check({tag, "_addr"},  32'(mac_src_addr), 32'd0);
    check({tag, "_done"},  32'(timestep_done), 32'd0);
    check({tag, "_index"}, 32'(timestep_index), 32'd0);
    check({tag, "_count"}, 32'(spike_count), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic check_boundary(input int idx, input int cnt);
    check("bnd_done",  32'(timestep_done), 32'd1);
    check("bnd_index", 32'(timestep_index), 32'(idx));
    check("bnd_count", 32'(spike_count), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    run_en = 1'b1;
    rv = 4'b0;
    ra[0] = 12'd3; ra[1] = 12'd7; ra[2] = 12'd5; ra[3] = 12'd9;
    g = 0;
    repeat (3) step();
    check_reset("por");

    // Test 1: set pulse then an empty timestep
    rst_n = 1'b1;
    #1;
    check("c0_set", 32'(mac_set), 32'd0);
    check("c0_busy", 32'(busy), 32'd0);
    step();
    check("c1_set", 32'(mac_set), 32'd1);
    check("c1_busy", 32'(busy), 32'd1);
    check("c1_state", 32'(dbg_state), 32'd0);
    step();
    check("c2_set", 32'(mac_set), 32'd1);
    step();
    check("c3_set", 32'(mac_set), 32'd0);
    check("c3_state", 32'(dbg_state), 32'd2);
    for (int k = 0; k < 16; k++) ts_cycle(k, 4'b0);
    check_boundary(1, 0);
    check("sat_done", 32'(s_done), 32'd1);
    check("sat_count", 32'(s_spike_count), 32'd7);

    // Test 2: all four requesters continuously valid for two timesteps
    rv = 4'hF;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 16; k++) begin
        if (k <= 13) begin
          ts_cycle(k, 4'(1 << (g % 4)));
          g++;
        end else begin
          ts_cycle(k, 4'b0);
        end
      end
      check_boundary(2 + t, 14);
    end

    // Test 3: request raised only in the clear cycle
    rv = 4'b0;
    for (int k = 0; k < 15; k++) ts_cycle(k, 4'b0);
    rv[2] = 1'b1;
    ra[2] = 12'd7;
    ts_cycle(15, 4'b0);
    check_boundary(4, 0);

    // Test 4: drop run_en mid-timestep, then resume from IDLE
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin
        check("t3_src_valid", 32'(mac_src_valid), 32'd1);
        check("t3_src_addr", 32'(mac_src_addr), 32'd7);
        rv = 4'b0;
      end
      if (k == 2) begin
        check("hold_valid", 32'(mac_src_valid), 32'd0);
        check("hold_addr", 32'(mac_src_addr), 32'd7);
      end
      if (k == 5) run_en = 1'b0;
      ts_cycle(k, (k == 0) ? 4'b0100 : 4'b0);
    end
    check_boundary(5, 1);
    check("idle_state", 32'(dbg_state), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    ra[2] = 12'd5;
    rv = 4'b0001;
    #1;
    check("idle_ready0", 32'(req_ready), 32'd0);
    step();
    check("idle_done_low", 32'(timestep_done), 32'd0);
    check("idle_state1", 32'(dbg_state), 32'd1);
    check("idle_ready1", 32'(req_ready), 32'd0);
    step();
    run_en = 1'b1;
    #1;
    check("idle_ready2", 32'(req_ready), 32'd0);
    step();
    check("resume_state", 32'(dbg_state), 32'd2);
    check("resume_busy", 32'(busy), 32'd1);
    check("resume_index", 32'(timestep_index), 32'd5);
    ts_cycle(0, 4'b0001);

    // Test 5: reset at ts_cnt 8 with requests pending
    rv = 4'hF;
    g = 1;
    for (int k = 1; k < 8; k++) begin
      ts_cycle(k, 4'(1 << (g % 4)));
      g++;
    end
    rst_n = 1'b0;
    #1;
    check("rst_gate", 32'(req_ready), 32'd0);
    step();
    check_reset("mid");
    rst_n = 1'b1;
    #1;
    check("r0_set", 32'(mac_set), 32'd0);
    check("r0_ready", 32'(req_ready), 32'd0);
    step();
    check("r1_set", 32'(mac_set), 32'd1);
    check("r1_ready", 32'(req_ready), 32'd0);
    step();
    check("r2_set", 32'(mac_set), 32'd1);
    step();
    check("r3_state", 32'(dbg_state), 32'd2);
    ts_cycle(0, 4'b0001);
    rv = 4'b0;
    step();
    step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
